// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low key matrix one column at a time, classifies each
// full 4-column frame, debounces press/release over whole frames and
// presents the accepted key as a code, a one-cycle strobe and a held level.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV        = 50000,  // clk_50M cycles per scan tick, >= 2
    parameter int DEBOUNCE_FRAMES = 5       // identical frames to accept, >= 1
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    output logic       KeyHeld
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // ROW synchronizer
    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;

    // Scan timing
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       col_idx_reg;
    logic             tick;

    // Frame accumulator: hit count saturates at 2 (only 0 / 1 / many matter)
    logic [1:0]       acc_cnt_reg;
    logic [3:0]       acc_code_reg;
    logic             frame_done_reg;

    // Per-column analysis of the sampled rows
    logic [3:0]       row_hit;
    logic [2:0]       col_hits;
    logic [1:0]       col_row;
    logic [1:0]       base_cnt;
    logic [3:0]       base_code;
    logic [2:0]       sum_cnt;
    logic [1:0]       merged_cnt;
    logic [3:0]       merged_code;

    // Debounce FSM
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [3:0]       cand_reg, cand_next;
    logic [3:0]       code_reg, code_next;
    logic             valid_reg, valid_next;
    logic             held_reg, held_next;
    logic             frame_none;
    logic             frame_single;

    // Two-flop synchronizer; idle level is all rows high (released)
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= ROW;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign tick = (div_reg == DIV_LAST);

    // Scan divider and column index; the column moves on the same tick it is sampled
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            div_reg     <= '0;
            col_idx_reg <= 2'd0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick) begin
                col_idx_reg <= col_idx_reg + 2'd1;
            end
        end
    end

    assign COL = ~(4'b0001 << col_idx_reg);

    // Rows are active-low: a low row on the driven column is a hit
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row_hit
            assign row_hit[gi] = ~row_sync_reg[gi];
        end
    endgenerate

    // Count hits in the current column and pick the lowest hit row
    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_hit[i]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(i);
            end
        end
    end

    // Merge this column into the frame; column 0 starts a fresh frame
    always_comb begin
        base_cnt    = (col_idx_reg == 2'd0) ? 2'd0 : acc_cnt_reg;
        base_code   = (col_idx_reg == 2'd0) ? 4'd0 : acc_code_reg;
        sum_cnt     = {1'b0, base_cnt} + col_hits;
        merged_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        merged_code = (base_cnt == 2'd0 && col_hits != 3'd0) ? {col_row, col_idx_reg}
                                                               : base_code;
    end

    // Frame accumulator; the col-3 sample closes the frame for the FSM
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_reg    <= 2'd0;
            acc_code_reg   <= 4'd0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= tick && (col_idx_reg == 2'd3);
            if (tick) begin
                acc_cnt_reg  <= merged_cnt;
                acc_code_reg <= merged_code;
            end
        end
    end

    assign frame_none   = (acc_cnt_reg == 2'd0);
    assign frame_single = (acc_cnt_reg == 2'd1);

    // FSM state and registered outputs
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cand_reg  <= 4'd0;
            code_reg  <= 4'd0;
            valid_reg <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
            held_reg  <= held_next;
        end
    end

    // Debounce decisions, taken only in the cycle after a frame completes
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        code_next  = code_reg;
        held_next  = held_reg;
        valid_next = 1'b0;
        cnt_inc    = cnt_reg + CNT_ONE;
        if (frame_done_reg) begin
            case (state_reg)
                IDLE: begin
                    if (frame_single) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            code_next  = acc_code_reg;
                            valid_next = 1'b1;
                            held_next  = 1'b1;
                            cnt_next   = '0;
                            state_next = PRESSED;
                        end else begin
                            cand_next  = acc_code_reg;
                            cnt_next   = CNT_ONE;
                            state_next = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (frame_single) begin
                        if (acc_code_reg == cand_reg) begin
                            if (cnt_inc >= DEB_TARGET) begin
                                code_next  = cand_reg;
                                valid_next = 1'b1;
                                held_next  = 1'b1;
                                cnt_next   = '0;
                                state_next = PRESSED;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end else begin
                            cand_next = acc_code_reg;
                            cnt_next  = CNT_ONE;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                PRESSED: begin
                    // Rollover and extra keys are ignored until a clean release
                    if (frame_none) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            held_next  = 1'b0;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            cnt_next   = CNT_ONE;
                            state_next = DEB_RELEASE;
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (frame_none) begin
                        if (cnt_inc >= DEB_TARGET) begin
                            held_next  = 1'b0;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = PRESSED;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign KeyCode  = code_reg;
    assign KeyValid = valid_reg;
    assign KeyHeld  = held_reg;

endmodule
